// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the imem/dmem memory port arbiter.
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;
  localparam bit CH_I = 1'b0;
  localparam bit CH_D = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} arb_state_t;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_MASK_W-1:0] rmask;
    logic [MEM_MASK_W-1:0] wmask;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  valid;
  } mem_req_t;
endpackage

// File: rtl/arb_req_latch.sv
// arb_req_latch: per-channel pending request register with protocol-violation detect.
module arb_req_latch
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_MASK_W-1:0] rmask,
  input  logic [MEM_MASK_W-1:0] wmask,
  input  logic [MEM_DATA_W-1:0] wdata,
  input  logic                  busy,
  input  logic                  clr,
  output mem_req_t              req,
  output logic                  viol
);
  logic new_req, occupied;
  assign new_req = |rmask || |wmask;
  // a pending entry being issued this cycle frees the slot for a new request
  assign occupied = (req.valid && !clr) || busy;
  assign viol = new_req && (occupied || (|rmask && |wmask));
  always_ff @(posedge clk) begin
    if (rst)
      req <= '0;
    else if (new_req && !viol)
      req <= '{addr: addr, rmask: rmask, wmask: wmask, wdata: wdata, valid: 1'b1};
    else if (clr)
      req.valid <= 1'b0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined memory port between imem and dmem channels.
// Define ARB_RR_EN for round-robin priority; default is fixed dmem-over-imem.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rmask,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rmask,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                error
);
  arb_state_t state_q, state_d;
  mem_req_t pi, pd, win;
  logic issue, win_ch, viol_i, viol_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  arb_req_latch u_latch_i (
    .clk(clk), .rst(rst),
    .addr(imem_addr), .rmask(imem_rmask), .wmask('0), .wdata('0),
    .busy(state_q == WAIT_I && !mem_resp),
    .clr(issue && win_ch == CH_I),
    .req(pi), .viol(viol_i)
  );

  arb_req_latch u_latch_d (
    .clk(clk), .rst(rst),
    .addr(dmem_addr), .rmask(dmem_rmask), .wmask(dmem_wmask), .wdata(dmem_wdata),
    .busy(state_q == WAIT_D && !mem_resp),
    .clr(issue && win_ch == CH_D),
    .req(pd), .viol(viol_d)
  );

`ifdef ARB_RR_EN
  logic last_q;
  assign win_ch = (pd.valid && (!pi.valid || last_q == CH_I)) ? CH_D : CH_I;
  always_ff @(posedge clk) begin
    if (rst)
      last_q <= CH_I;
    else if (issue)
      last_q <= win_ch;
  end
`else
  assign win_ch = pd.valid ? CH_D : CH_I;
`endif

  assign win = (win_ch == CH_D) ? pd : pi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q  <= win.addr;
        wdata_q <= win.wdata;
      end
      if (viol_i || viol_d || (state_q == IDLE && mem_resp))
        error <= 1'b1;
    end
  end

  // a response completes the in-flight request; the next issue waits one cycle in IDLE
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    imem_resp = 1'b0;
    dmem_resp = 1'b0;
    if (!rst) begin
      if (state_q == IDLE && (pi.valid || pd.valid)) begin
        issue   = 1'b1;
        state_d = (win_ch == CH_D) ? WAIT_D : WAIT_I;
      end else if (state_q == WAIT_I && mem_resp) begin
        imem_resp = 1'b1;
        state_d   = IDLE;
      end else if (state_q == WAIT_D && mem_resp) begin
        dmem_resp = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  assign mem_rmask  = issue ? win.rmask : '0;
  assign mem_wmask  = issue ? win.wmask : '0;
  assign mem_addr   = issue ? win.addr : addr_q;
  assign mem_wdata  = issue ? win.wdata : wdata_q;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a variable-latency memory model.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] imem_addr = 0, dmem_addr = 0, dmem_wdata = 0, mem_rdata = 0;
  logic [3:0] imem_rmask = 0, dmem_rmask = 0, dmem_wmask = 0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_rmask, mem_wmask;
  logic imem_resp, dmem_resp, error, mem_resp = 0;

  typedef struct {int cyc; logic [31:0] addr; logic [3:0] rmask; logic [3:0] wmask; logic [31:0] wdata;} iss_t;
  typedef struct {bit ch; int cyc;} rsp_t;
  typedef struct {bit rd; logic [31:0] data;} dexp_t;
  iss_t iss_log[$];
  rsp_t rsp_log[$];
  logic [31:0] exp_i[$];
  dexp_t exp_d[$];
  int checks = 0, errors = 0, cyc = 0, mem_cnt = 0, mem_lat = 3;
  bit rand_lat = 0, busy_i = 0, busy_d = 0;
  logic [31:0] mem_a = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    #1;
    mem_resp = 0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_resp = 1;
        mem_rdata = mem_word(mem_a);
      end
    end
  end

  always @(negedge clk) begin
    if ((|mem_rmask === 1'b1) || (|mem_wmask === 1'b1)) begin
      iss_log.push_back('{cyc, mem_addr, mem_rmask, mem_wmask, mem_wdata});
      mem_a = mem_addr;
      mem_cnt = rand_lat ? int'($urandom_range(1, 8)) : mem_lat;
    end
    if (imem_resp === 1'b1) begin
      checks++;
      if (exp_i.size() == 0) begin
        errors++;
        $display("FAIL imem_resp_unexpected at cycle %0d", cyc);
      end else begin
        logic [31:0] e;
        e = exp_i.pop_front();
        if (imem_rdata !== e) begin
          errors++;
          $display("FAIL imem_rdata got %h want %h", imem_rdata, e);
        end
      end
      rsp_log.push_back('{1'b0, cyc});
      busy_i = 0;
    end
    if (dmem_resp === 1'b1) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL dmem_resp_unexpected at cycle %0d", cyc);
      end else begin
        dexp_t e;
        e = exp_d.pop_front();
        if (e.rd && dmem_rdata !== e.data) begin
          errors++;
          $display("FAIL dmem_rdata got %h want %h", dmem_rdata, e.data);
        end
      end
      rsp_log.push_back('{1'b1, cyc});
      busy_d = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(logic [31:0] a);
    imem_addr = a;
    imem_rmask = 4'hF;
    exp_i.push_back(mem_word(a));
    busy_i = 1;
  endtask

  task automatic set_d(logic [31:0] a, logic [3:0] rm, logic [3:0] wm, logic [31:0] wd);
    dmem_addr = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    exp_d.push_back('{rm != 0, mem_word(a)});
    busy_d = 1;
  endtask

  task automatic pulse;
    tick;
    imem_rmask = 0;
    dmem_rmask = 0;
    dmem_wmask = 0;
  endtask

  task automatic wait_rsp(int n);
    int b = 0;
    while (rsp_log.size() < n && b < 60) begin
      tick;
      b++;
    end
  endtask

  task automatic clear_logs;
    iss_log.delete();
    rsp_log.delete();
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) tick;
    checks++; if (mem_rmask !== 4'h0) begin errors++; $display("FAIL rst_rmask got %h want 0", mem_rmask); end
    checks++; if (mem_wmask !== 4'h0) begin errors++; $display("FAIL rst_wmask got %h want 0", mem_wmask); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    checks++; if ({imem_resp, dmem_resp} !== 2'b00) begin errors++; $display("FAIL rst_resp got %b want 00", {imem_resp, dmem_resp}); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error); end
    rst = 0;
    tick;
  endtask

  task automatic test_imem_read;
    int c;
    clear_logs;
    mem_lat = 3;
    c = cyc;
    set_i(32'h0000_1000);
    pulse;
    wait_rsp(1);
    checks++;
    if (iss_log.size() != 1) begin
      errors++; $display("FAIL ird_issue_count got %0d want 1", iss_log.size());
    end else begin
      checks++; if (iss_log[0].cyc != c + 1) begin errors++; $display("FAIL ird_issue_cyc got %0d want %0d", iss_log[0].cyc, c + 1); end
      checks++; if (iss_log[0].addr !== 32'h1000) begin errors++; $display("FAIL ird_addr got %h want 00001000", iss_log[0].addr); end
      checks++; if (iss_log[0].rmask !== 4'hF || iss_log[0].wmask !== 4'h0) begin errors++; $display("FAIL ird_masks got %h/%h want f/0", iss_log[0].rmask, iss_log[0].wmask); end
    end
    checks++;
    if (rsp_log.size() != 1) begin
      errors++; $display("FAIL ird_resp_count got %0d want 1", rsp_log.size());
    end else begin
      checks++; if (rsp_log[0].ch != 1'b0 || rsp_log[0].cyc != c + 4) begin errors++; $display("FAIL ird_resp got ch%0d cyc %0d want ch0 cyc %0d", rsp_log[0].ch, rsp_log[0].cyc, c + 4); end
    end
  endtask

  task automatic test_dmem_write;
    clear_logs;
    mem_lat = 2;
    set_d(32'h0000_2004, 4'h0, 4'h3, 32'hDEAD_BEEF);
    pulse;
    wait_rsp(1);
    repeat (4) tick;
    checks++;
    if (iss_log.size() != 1) begin
      errors++; $display("FAIL dwr_issue_count got %0d want 1", iss_log.size());
    end else begin
      checks++; if (iss_log[0].wmask !== 4'h3 || iss_log[0].rmask !== 4'h0) begin errors++; $display("FAIL dwr_masks got %h/%h want 0/3", iss_log[0].rmask, iss_log[0].wmask); end
      checks++; if (iss_log[0].addr !== 32'h2004 || iss_log[0].wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dwr_addr_data got %h/%h want 00002004/deadbeef", iss_log[0].addr, iss_log[0].wdata); end
    end
    checks++;
    if (rsp_log.size() != 1 || rsp_log[0].ch != 1'b1) begin
      errors++; $display("FAIL dwr_resp got %0d resps want one on dmem", rsp_log.size());
    end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dwr_wdata_hold got %h want deadbeef", mem_wdata); end
  endtask

  task automatic test_priority;
    int c;
    logic [31:0] first, second;
`ifdef ARB_RR_EN
    first = 32'h4000; second = 32'h3000;
`else
    first = 32'h3000; second = 32'h4000;
`endif
    clear_logs;
    mem_lat = 2;
    c = cyc;
    set_d(32'h3000, 4'hF, 4'h0, 32'h0);
    set_i(32'h4000);
    pulse;
    wait_rsp(2);
    checks++;
    if (iss_log.size() != 2 || rsp_log.size() != 2) begin
      errors++; $display("FAIL prio_count got %0d issues %0d resps want 2 2", iss_log.size(), rsp_log.size());
    end else begin
      checks++; if (iss_log[0].addr !== first || iss_log[0].cyc != c + 1) begin errors++; $display("FAIL prio_first got %h@%0d want %h@%0d", iss_log[0].addr, iss_log[0].cyc, first, c + 1); end
      checks++; if (iss_log[1].addr !== second || iss_log[1].cyc != rsp_log[0].cyc + 1) begin errors++; $display("FAIL prio_second got %h@%0d want %h@%0d", iss_log[1].addr, iss_log[1].cyc, second, rsp_log[0].cyc + 1); end
    end
  endtask

  task automatic test_double_request;
    clear_logs;
    mem_lat = 4;
    set_i(32'h5000);
    pulse;
    tick;
    imem_addr = 32'h6000;
    imem_rmask = 4'hF;
    pulse;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL dbl_error got %b want 1", error); end
    wait_rsp(1);
    repeat (6) tick;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL dbl_error_sticky got %b want 1", error); end
    checks++; if (iss_log.size() != 1 || rsp_log.size() != 1) begin errors++; $display("FAIL dbl_count got %0d issues %0d resps want 1 1", iss_log.size(), rsp_log.size()); end
  endtask

  task automatic test_reset_mid;
    int c;
    clear_logs;
    mem_lat = 6;
    set_d(32'h7000, 4'hF, 4'h0, 32'h0);
    pulse;
    tick;
    rst = 1;
    tick;
    rst = 0;
    exp_d.delete();
    busy_d = 0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rmid_error_clr got %b want 0", error); end
    repeat (6) tick;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL rmid_late_resp_error got %b want 1", error); end
    checks++; if (rsp_log.size() != 0) begin errors++; $display("FAIL rmid_resp got %0d resps want 0", rsp_log.size()); end
    clear_logs;
    mem_lat = 2;
    c = cyc;
    set_i(32'h8000);
    pulse;
    wait_rsp(1);
    checks++;
    if (iss_log.size() != 1 || rsp_log.size() != 1) begin
      errors++; $display("FAIL rmid_after_count got %0d issues %0d resps want 1 1", iss_log.size(), rsp_log.size());
    end else begin
      checks++; if (iss_log[0].cyc != c + 1 || rsp_log[0].ch != 1'b0 || rsp_log[0].cyc != c + 3) begin errors++; $display("FAIL rmid_after got issue %0d resp %0d want %0d %0d", iss_log[0].cyc, rsp_log[0].cyc, c + 1, c + 3); end
    end
  endtask

  task automatic test_random;
    int b;
    rst = 1;
    tick;
    rst = 0;
    clear_logs;
    rand_lat = 1;
    for (int i = 0; i < 1000; i++) begin
      bit ch;
      ch = 1'($urandom_range(0, 1));
      b = 0;
      while ((ch ? busy_d : busy_i) && b < 60) begin tick; b++; end
      if (b >= 60) begin
        errors++; $display("FAIL rand_timeout at request %0d", i);
        break;
      end
      if (ch) begin
        if ($urandom_range(0, 1) == 1) set_d($urandom & 32'hFFFF_FFFC, 4'hF, 4'h0, 32'h0);
        else set_d($urandom & 32'hFFFF_FFFC, 4'h0, 4'($urandom_range(1, 15)), $urandom);
      end else begin
        set_i($urandom & 32'hFFFF_FFFC);
      end
      pulse;
    end
    b = 0;
    while ((busy_i || busy_d) && b < 60) begin tick; b++; end
    checks++; if (exp_i.size() != 0 || exp_d.size() != 0) begin errors++; $display("FAIL rand_outstanding got %0d/%0d want 0/0", exp_i.size(), exp_d.size()); end
    checks++; if (rsp_log.size() != 1000 || iss_log.size() != 1000) begin errors++; $display("FAIL rand_counts got %0d resps %0d issues want 1000", rsp_log.size(), iss_log.size()); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rand_error got %b want 0", error); end
    rand_lat = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_imem_read;
    test_dmem_write;
    test_priority;
    test_double_request;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
